// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a frame-synchronous commit of new display data.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan_driver #(
  parameter int ON_CYCLES  = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic {ST_ON, ST_GAP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     digit_q, digit_d;
  logic [15:0]    display_q, display_d;
  logic [15:0]    pending_q, pending_d;
  logic           pending_flag_q, pending_flag_d;
  logic [6:0]     seg_q, seg_d;
  logic [3:0]     an_q, an_d;
  logic           end_slot;
  logic           blank;
  logic [3:0]     nib;

  function automatic logic [6:0] hexdecode(input logic [3:0] h);
    case (h)
      4'h0: hexdecode = 7'b1000000;
      4'h1: hexdecode = 7'b1111001;
      4'h2: hexdecode = 7'b0100100;
      4'h3: hexdecode = 7'b0110000;
      4'h4: hexdecode = 7'b0011001;
      4'h5: hexdecode = 7'b0010010;
      4'h6: hexdecode = 7'b0000010;
      4'h7: hexdecode = 7'b1111000;
      4'h8: hexdecode = 7'b0000000;
      4'h9: hexdecode = 7'b0010000;
      4'hA: hexdecode = 7'b0001000;
      4'hB: hexdecode = 7'b0000011;
      4'hC: hexdecode = 7'b1000110;
      4'hD: hexdecode = 7'b0100001;
      4'hE: hexdecode = 7'b0000110;
      default: hexdecode = 7'b0001110;
    endcase
  endfunction

  assign data_ready = !pending_flag_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign nib        = display_q[4*digit_q +: 4];

`ifdef SEVENSEG_LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (digit_q)
      2'd1: blank = (display_q[15:4] == 12'h000);
      2'd2: blank = (display_q[15:8] == 8'h00);
      2'd3: blank = (display_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    digit_d        = digit_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    end_slot       = 1'b0;

    case (state_q)
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            end_slot = 1'b1;
          end
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) end_slot = 1'b1;
      end
    endcase

    if (end_slot) begin
      state_d = ST_ON;
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      // Commit only as digit 3 hands back to digit 0, so no frame mixes values
      if (digit_q == 2'd3 && pending_flag_q) begin
        display_d      = pending_q;
        pending_flag_d = 1'b0;
      end
    end

    if (data_valid && !pending_flag_q) begin
      pending_d      = data_in;
      pending_flag_d = 1'b1;
    end

    seg_d = 7'b1111111;
    an_d  = 4'b1111;
    if (state_q == ST_ON && !blank) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hexdecode(nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ON;
      cnt_q          <= '0;
      digit_q        <= 2'd0;
      display_q      <= 16'h0000;
      pending_q      <= 16'h0000;
      pending_flag_q <= 1'b0;
      seg_q          <= 7'b1111111;
      an_q           <= 4'b1111;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      digit_q        <= digit_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench: main driver (ON=4, GAP=2) plus a gapless instance (ON=4, GAP=0).
// Expected scan pattern is derived from the cycle count since reset release.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din, din2;
  logic        dv, dv2;
  logic        rdy, rdy2;
  logic [6:0]  seg, seg2;
  logic [3:0]  an, an2;

  int errors = 0;
  int checks = 0;
  int n_edges;

  sevenseg_scan_driver #(.ON_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .reset(rst), .data_in(din), .data_valid(dv),
    .data_ready(rdy), .seg(seg), .an(an)
  );

  sevenseg_scan_driver #(.ON_CYCLES(4), .GAP_CYCLES(0)) u_nogap (
    .clk(clk), .reset(rst), .data_in(din2), .data_valid(dv2),
    .data_ready(rdy2), .seg(seg2), .an(an2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    int guard = 0;
    while (n_edges < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n_edges != n) begin
      checks++;
      errors++;
      $display("FAIL wait_to: at edge %0d expected %0d", n_edges, n);
    end
  endtask

  function automatic logic [6:0] hexd(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // {an, seg} expected after edge p+1 for a display value v
  function automatic logic [10:0] exp_out(input int p, input logic [15:0] v, input int gap);
    int s = 4 + gap;
    int w = p % s;
    int d = (p / s) % 4;
    logic [3:0] a;
    if (w >= 4) return {4'b1111, 7'b1111111};
`ifdef SEVENSEG_LZ_BLANK_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) return {4'b1111, 7'b1111111};
`endif
    a = 4'b0001 << d;
    return {~a, hexd(v[4*d +: 4])};
  endfunction

  task automatic check_frame(input int f, input logic [15:0] v);
    logic [10:0] x;
    for (int e = 24*f + 1; e <= 24*f + 24; e++) begin
      wait_to(e);
      x = exp_out(e - 1, v, 2);
      chk($sformatf("an f%0d e%0d v%h", f, e, v), an, x[10:7]);
      chk($sformatf("seg f%0d e%0d v%h", f, e, v), seg, x[6:0]);
    end
  endtask

  initial begin
    logic [10:0] x;
    rst = 1'b1; din = '0; dv = 1'b0; din2 = '0; dv2 = 1'b0;
    #1;
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_ready", rdy, 1'b1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // idle scan of value 0
    check_frame(0, 16'h0000);
    chk("idle_ready", rdy, 1'b1);

    // single-cycle transfer mid-frame
    wait_to(30); din = 16'hA5F0; dv = 1'b1;
    wait_to(31); chk("a5f0_ready_drop", rdy, 1'b0); dv = 1'b0; din = 16'hFFFF;
    wait_to(47); chk("a5f0_ready_held", rdy, 1'b0);
    wait_to(48); chk("a5f0_ready_back", rdy, 1'b1);
    check_frame(2, 16'hA5F0);

    // second value held on the bus while the first is pending
    wait_to(75); din = 16'h1234; dv = 1'b1;
    wait_to(76); chk("1234_ready_drop", rdy, 1'b0); din = 16'h5678;
    wait_to(95); chk("5678_blocked", rdy, 1'b0);
    wait_to(96); chk("boundary_ready", rdy, 1'b1);
    wait_to(97); chk("5678_taken", rdy, 1'b0); dv = 1'b0;
    check_frame(4, 16'h1234);
    check_frame(5, 16'h5678);

    // asynchronous reset during digit 2 with data pending
    wait_to(145); din = 16'hBEEF; dv = 1'b1;
    wait_to(146); chk("beef_pending", rdy, 1'b0); dv = 1'b0;
    wait_to(157); chk("digit2_lit", an, 4'b1011);
    rst = 1'b1;
    #1;
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_ready", rdy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check_frame(0, 16'h0000);
    chk("post_rst_ready", rdy, 1'b1);

    // leading-zero value on main driver, 8888 on gapless driver
    rst = 1'b1; din = 16'h0070; dv = 1'b1; din2 = 16'h8888; dv2 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_to(1); dv = 1'b0; dv2 = 1'b0;
    chk("lz_pending", rdy, 1'b0);
    chk("ng_pending", rdy2, 1'b0);
    check_frame(1, 16'h0070);
    for (int e = 49; e <= 64; e++) begin
      wait_to(e);
      x = exp_out(e - 1, 16'h8888, 0);
      chk($sformatf("ng_an e%0d", e), an2, x[10:7]);
      chk($sformatf("ng_seg e%0d", e), seg2, x[6:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
